// File: rtl/sap_sequencer.sv
// Timing and micro-step sequencer for the SAP core: programmable clock-enable divider,
// micro-step counter, RUN/STEP/INSTR/PAUSE modes, halt latch and retired-instruction counter.
module sap_sequencer #(
    parameter int  INSTRUCTION_STEPS = 8,
    parameter int  DIV_WIDTH         = 16,
    parameter int  CNT_WIDTH         = 16,
    localparam int STEP_W            = $clog2(INSTRUCTION_STEPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic [1:0]           i_mode,
    input  logic                 i_step_req,
    input  logic                 i_halt,
    input  logic                 i_adv,
    input  logic                 i_resume,
    output logic                 o_clk_en,
    output logic [STEP_W-1:0]    o_step,
    output logic                 o_halted,
    output logic                 o_instr_done,
    output logic [CNT_WIDTH-1:0] o_instr_count
);

    typedef enum logic [1:0] {
        ST_PAUSED = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(INSTRUCTION_STEPS - 1);

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic                   req_prev_q, req_prev_d;
    logic                   req_pend_q, req_pend_d;
    logic [1:0]             mode_prev_q, mode_prev_d;
    logic                   instr_done_q, instr_done_d;
    logic [CNT_WIDTH-1:0]   instr_count_q, instr_count_d;

    logic tick;
    logic clk_en;
    logic at_last;
    logic retire;
    logic req_edge;

    always_comb begin
        tick     = (div_cnt_q >= i_div);
        clk_en   = tick && (state_q == ST_ACTIVE) && (i_mode != 2'd3);
        at_last  = (step_q == LAST_STEP);
        retire   = clk_en && !i_halt && (i_adv || at_last);
        req_edge = i_step_req && !req_prev_q;

        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        step_d        = step_q;
        req_prev_d    = i_step_req;
        req_pend_d    = req_pend_q;
        mode_prev_d   = i_mode;
        instr_done_d  = retire;
        instr_count_d = retire ? instr_count_q + CNT_WIDTH'(1) : instr_count_q;

        // The divider free-runs in PAUSED so the enable phase is continuous across pauses.
        if (state_q != ST_HALTED) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);
        end

        if (clk_en && !i_halt) begin
            step_d = (i_adv || at_last) ? '0 : step_q + STEP_W'(1);
        end

        case (state_q)
            ST_PAUSED: begin
                if ((i_mode == 2'd0) ||
                    (req_pend_q && ((i_mode == 2'd1) || (i_mode == 2'd2)))) begin
                    state_d    = ST_ACTIVE;
                    req_pend_d = 1'b0;
                end else if (req_edge) begin
                    req_pend_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // Halt outranks every other exit; the halting enable itself is still issued.
                if (clk_en && i_halt) begin
                    state_d = ST_HALTED;
                end else if (i_mode == 2'd3) begin
                    state_d = ST_PAUSED;
                end else if ((mode_prev_q == 2'd0) && (i_mode != 2'd0)) begin
                    state_d = ST_PAUSED;
                end else if (clk_en && ((i_mode == 2'd1) || ((i_mode == 2'd2) && retire))) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_HALTED: begin
                if (i_resume) begin
                    state_d    = ST_PAUSED;
                    step_d     = '0;
                    div_cnt_d  = '0;
                    req_prev_d = 1'b0;
                    req_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_PAUSED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_PAUSED;
            div_cnt_q     <= '0;
            step_q        <= '0;
            req_prev_q    <= 1'b0;
            req_pend_q    <= 1'b0;
            mode_prev_q   <= 2'd0;
            instr_done_q  <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            step_q        <= step_d;
            req_prev_q    <= req_prev_d;
            req_pend_q    <= req_pend_d;
            mode_prev_q   <= mode_prev_d;
            instr_done_q  <= instr_done_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign o_clk_en      = clk_en;
    assign o_step        = step_q;
    assign o_halted      = (state_q == ST_HALTED);
    assign o_instr_done  = instr_done_q;
    assign o_instr_count = instr_count_q;

endmodule

// File: tb/tb_sap_sequencer.sv
// Self-checking bench for sap_sequencer: each scenario predicts enable cycles, step and
// retire counts arithmetically from the divider phase and the mode rules.
module tb_sap_sequencer;

    localparam int STEPS = 8;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int SW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] i_div = '0;
    logic [1:0]    i_mode = 2'd3;
    logic          i_step_req = 1'b0;
    logic          i_halt = 1'b0;
    logic          i_adv = 1'b0;
    logic          i_resume = 1'b0;
    logic          o_clk_en;
    logic [SW-1:0] o_step;
    logic          o_halted;
    logic          o_instr_done;
    logic [CW-1:0] o_instr_count;

    int vectors = 0;
    int miscompares = 0;

    sap_sequencer #(
        .INSTRUCTION_STEPS(STEPS),
        .DIV_WIDTH(DW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_div(i_div),
        .i_mode(i_mode),
        .i_step_req(i_step_req),
        .i_halt(i_halt),
        .i_adv(i_adv),
        .i_resume(i_resume),
        .o_clk_en(o_clk_en),
        .o_step(o_step),
        .o_halted(o_halted),
        .o_instr_done(o_instr_done),
        .o_instr_count(o_instr_count)
    );

    always #5 clk = ~clk;

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Leaves the bench at the middle of cycle 0: the first rising edge after this is edge 1.
    task automatic do_reset(input logic [1:0] mode, input int d);
        rst_n = 1'b0;
        i_div = DW'(d);
        i_mode = mode;
        i_step_req = 1'b0;
        i_halt = 1'b0;
        i_adv = 1'b0;
        i_resume = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sample();
    endtask

    // In RUN from reset the divider phase in cycle k is k mod (d+1); enables need ACTIVE (k>=1).
    task automatic run_check(input int d, input int n, input bit noise, input string tag);
        int en_cnt;
        bit prev_ret;
        bit exp_en;
        en_cnt = 0;
        prev_ret = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                drive_edge();
                if (noise) begin
                    i_resume = 1'($urandom_range(0, 1));
                    i_step_req = 1'($urandom_range(0, 1));
                end
                sample();
            end
            exp_en = (k >= 1) && ((k % (d + 1)) == d);
            vectors++;
            if (o_clk_en !== exp_en) begin
                miscompares++;
                $display("FAIL %s_clk_en: cycle %0d got %0b expected %0b", tag, k, o_clk_en, exp_en);
            end
            vectors++;
            if (o_step !== SW'(en_cnt % STEPS)) begin
                miscompares++;
                $display("FAIL %s_step: cycle %0d got %0d expected %0d", tag, k, o_step, en_cnt % STEPS);
            end
            vectors++;
            if (o_instr_done !== prev_ret) begin
                miscompares++;
                $display("FAIL %s_done: cycle %0d got %0b expected %0b", tag, k, o_instr_done, prev_ret);
            end
            vectors++;
            if (o_instr_count !== CW'(en_cnt / STEPS)) begin
                miscompares++;
                $display("FAIL %s_count: cycle %0d got %0d expected %0d", tag, k, o_instr_count, en_cnt / STEPS);
            end
            vectors++;
            if (o_halted !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_halted: cycle %0d got %0b expected 0", tag, k, o_halted);
            end
            prev_ret = exp_en && ((en_cnt % STEPS) == STEPS - 1);
            if (exp_en) en_cnt++;
        end
        i_resume = 1'b0;
        i_step_req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2'd3, int'($urandom_range(0, 5)));
        vectors++;
        if (o_clk_en !== 1'b0) begin miscompares++; $display("FAIL reset_clk_en: got %0b expected 0", o_clk_en); end
        vectors++;
        if (o_step !== '0) begin miscompares++; $display("FAIL reset_step: got %0d expected 0", o_step); end
        vectors++;
        if (o_halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %0b expected 0", o_halted); end
        vectors++;
        if (o_instr_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", o_instr_done); end
        vectors++;
        if (o_instr_count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", o_instr_count); end
        // Leave a request pending in PAUSE, then reset must discard it.
        for (int k = 1; k <= 6; k++) begin
            drive_edge();
            i_step_req = (k == 2);
            sample();
            vectors++;
            if (o_clk_en !== 1'b0) begin miscompares++; $display("FAIL pause_clk_en: cycle %0d got %0b expected 0", k, o_clk_en); end
        end
        rst_n = 1'b0;
        #1;
        do_reset(2'd1, 0);
        for (int k = 1; k <= 10; k++) begin
            drive_edge();
            sample();
            vectors++;
            if (o_clk_en !== 1'b0) begin miscompares++; $display("FAIL reset_clears_req: cycle %0d got %0b expected 0", k, o_clk_en); end
        end
    endtask

    task automatic test_run();
        int d;
        do_reset(2'd0, 0);
        run_check(0, 40, 1'b0, "run_div0");
        do_reset(2'd0, 3);
        run_check(3, 40, 1'b0, "run_div3");
        d = int'($urandom_range(1, 5));
        do_reset(2'd0, d);
        run_check(d, 60, 1'b1, "run_rand");
    endtask

    task automatic test_div_change();
        int d0, r, c;
        bit exp_en;
        d0 = int'($urandom_range(3, 6));
        r = int'($urandom_range(2, d0 - 1));
        c = (d0 + 1) + r;
        do_reset(2'd0, d0);
        for (int k = 1; k <= c + 12; k++) begin
            drive_edge();
            if (k >= c) i_div = DW'(1);
            sample();
            exp_en = (k < c) ? ((k % (d0 + 1)) == d0) : (((k - c) % 2) == 0);
            vectors++;
            if (o_clk_en !== exp_en) begin
                miscompares++;
                $display("FAIL div_change: cycle %0d got %0b expected %0b", k, o_clk_en, exp_en);
            end
        end
    endtask

    // A request raised in cycle c enables at the first tick on or after cycle c+2.
    function automatic int first_tick(input int from, input int d);
        int k;
        k = from;
        while ((k % (d + 1)) != d) k++;
        return k;
    endfunction

    task automatic test_step();
        int d, e0, e1, e2, seen;
        bit exp_en;
        d = int'($urandom_range(0, 3));
        e0 = first_tick(5, d);
        e1 = first_tick(15, d);
        e2 = first_tick(25, d);
        seen = 0;
        do_reset(2'd1, d);
        for (int k = 1; k <= 40; k++) begin
            drive_edge();
            i_step_req = (k == 3) || (k == 13) || (k == 23);
            sample();
            exp_en = (k == e0) || (k == e1) || (k == e2);
            if (o_clk_en === 1'b1) seen++;
            vectors++;
            if (o_clk_en !== exp_en) begin
                miscompares++;
                $display("FAIL step_clk_en: cycle %0d got %0b expected %0b", k, o_clk_en, exp_en);
            end
        end
        vectors++;
        if (seen != 3) begin miscompares++; $display("FAIL step_enables: got %0d expected 3", seen); end
        vectors++;
        if (o_step !== SW'(3)) begin miscompares++; $display("FAIL step_final: got %0d expected 3", o_step); end
    endtask

    task automatic test_step_drop();
        int dc;
        bit exp_en;
        dc = int'($urandom_range(22, 40));
        do_reset(2'd1, 20);
        for (int k = 1; k <= 90; k++) begin
            drive_edge();
            i_step_req = (k == 19) || (k == dc);
            sample();
            exp_en = (k == 41);
            vectors++;
            if (o_clk_en !== exp_en) begin
                miscompares++;
                $display("FAIL step_drop: cycle %0d got %0b expected %0b", k, o_clk_en, exp_en);
            end
        end
        vectors++;
        if (o_step !== SW'(1)) begin miscompares++; $display("FAIL step_drop_final: got %0d expected 1", o_step); end
    endtask

    task automatic test_instr();
        int d, en_cnt;
        bit exp_en, done_next;
        d = int'($urandom_range(0, 3));
        en_cnt = 0;
        done_next = 1'b0;
        do_reset(2'd2, d);
        for (int k = 1; k <= 45; k++) begin
            drive_edge();
            i_step_req = (k == 2);
            i_adv = (en_cnt == 4);
            sample();
            exp_en = (k >= 4) && ((k % (d + 1)) == d) && (en_cnt < 5);
            vectors++;
            if (o_clk_en !== exp_en) begin
                miscompares++;
                $display("FAIL instr_clk_en: cycle %0d got %0b expected %0b", k, o_clk_en, exp_en);
            end
            vectors++;
            if (o_step !== SW'((en_cnt == 5) ? 0 : en_cnt)) begin
                miscompares++;
                $display("FAIL instr_step: cycle %0d got %0d expected %0d", k, o_step, (en_cnt == 5) ? 0 : en_cnt);
            end
            vectors++;
            if (o_instr_done !== done_next) begin
                miscompares++;
                $display("FAIL instr_done: cycle %0d got %0b expected %0b", k, o_instr_done, done_next);
            end
            vectors++;
            if (o_instr_count !== CW'((en_cnt == 5) ? 1 : 0)) begin
                miscompares++;
                $display("FAIL instr_count: cycle %0d got %0d expected %0d", k, o_instr_count, (en_cnt == 5) ? 1 : 0);
            end
            done_next = exp_en && (en_cnt == 4);
            if (exp_en) en_cnt++;
        end
        i_adv = 1'b0;
    endtask

    task automatic test_halt();
        int d, en_cnt, hcyc, en2;
        bit exp_en;
        d = int'($urandom_range(0, 3));
        en_cnt = 0;
        hcyc = -1;
        do_reset(2'd0, d);
        // Halt (with a simultaneous early-advance) on the enable at step 2 of the second instruction.
        for (int k = 1; (k < 200) && (hcyc < 0); k++) begin
            drive_edge();
            i_halt = (en_cnt == 10);
            i_adv = (en_cnt == 10);
            sample();
            exp_en = (k % (d + 1)) == d;
            vectors++;
            if (o_clk_en !== exp_en) begin
                miscompares++;
                $display("FAIL halt_pre_clk_en: cycle %0d got %0b expected %0b", k, o_clk_en, exp_en);
            end
            if (exp_en) begin
                if (en_cnt == 10) hcyc = k;
                else en_cnt++;
            end
        end
        vectors++;
        if (hcyc < 0) begin miscompares++; $display("FAIL halt_reached: got none expected halting enable"); end
        for (int k = 0; k < 50; k++) begin
            drive_edge();
            i_halt = 1'b0;
            i_adv = 1'b0;
            i_step_req = 1'($urandom_range(0, 1));
            sample();
            vectors++;
            if (o_clk_en !== 1'b0) begin miscompares++; $display("FAIL halted_clk_en: cycle +%0d got %0b expected 0", k, o_clk_en); end
            vectors++;
            if (o_halted !== 1'b1) begin miscompares++; $display("FAIL halted_flag: cycle +%0d got %0b expected 1", k, o_halted); end
            vectors++;
            if (o_step !== SW'(2)) begin miscompares++; $display("FAIL halted_step: cycle +%0d got %0d expected 2", k, o_step); end
            vectors++;
            if ((o_instr_count !== CW'(1)) || (o_instr_done !== 1'b0)) begin
                miscompares++;
                $display("FAIL halted_retire: cycle +%0d got count %0d done %0b expected count 1 done 0", k, o_instr_count, o_instr_done);
            end
        end
        drive_edge();
        i_step_req = 1'b0;
        i_resume = 1'b1;
        sample();
        vectors++;
        if (o_halted !== 1'b1) begin miscompares++; $display("FAIL resume_same_cycle: got %0b expected 1", o_halted); end
        drive_edge();
        i_resume = 1'b0;
        sample();
        vectors++;
        if ((o_halted !== 1'b0) || (o_step !== '0) || (o_clk_en !== 1'b0) || (o_instr_count !== CW'(1))) begin
            miscompares++;
            $display("FAIL resume_state: got halted %0b step %0d en %0b count %0d expected 0 0 0 1",
                     o_halted, o_step, o_clk_en, o_instr_count);
        end
        en2 = 0;
        for (int j = 1; j <= 20; j++) begin
            drive_edge();
            sample();
            exp_en = (j % (d + 1)) == d;
            vectors++;
            if (o_clk_en !== exp_en) begin
                miscompares++;
                $display("FAIL resume_clk_en: cycle +%0d got %0b expected %0b", j, o_clk_en, exp_en);
            end
            vectors++;
            if (o_step !== SW'(en2 % STEPS)) begin
                miscompares++;
                $display("FAIL resume_step: cycle +%0d got %0d expected %0d", j, o_step, en2 % STEPS);
            end
            if (exp_en) en2++;
        end
    endtask

    task automatic test_pause();
        bit exp_en;
        do_reset(2'd0, 0);
        for (int k = 1; k <= 12; k++) begin
            drive_edge();
            i_mode = (k == 6) ? 2'd3 : 2'd0;
            sample();
            exp_en = (k != 6) && (k != 7);
            vectors++;
            if (o_clk_en !== exp_en) begin
                miscompares++;
                $display("FAIL pause_suppress: cycle %0d got %0b expected %0b", k, o_clk_en, exp_en);
            end
        end
        i_mode = 2'd0;
    endtask

    task automatic test_reset_mid_run();
        do_reset(2'd0, 0);
        for (int k = 1; k <= 62; k++) begin
            drive_edge();
            sample();
        end
        vectors++;
        if ((o_step !== SW'(5)) || (o_instr_count !== CW'(7))) begin
            miscompares++;
            $display("FAIL midrun_pre: got step %0d count %0d expected 5 7", o_step, o_instr_count);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ((o_clk_en !== 1'b0) || (o_step !== '0) || (o_halted !== 1'b0) ||
            (o_instr_done !== 1'b0) || (o_instr_count !== '0)) begin
            miscompares++;
            $display("FAIL async_reset: got en %0b step %0d halted %0b done %0b count %0d expected all 0",
                     o_clk_en, o_step, o_halted, o_instr_done, o_instr_count);
        end
        do_reset(2'd0, 0);
        run_check(0, 30, 1'b0, "rerun");
    endtask

    initial begin
        test_reset();
        test_run();
        test_div_change();
        test_step();
        test_step_drop();
        test_instr();
        test_halt();
        test_pause();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
